// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Front end of the systolic-array controller. Buffers host instructions in
//   a FIFO and issues one per cycle on a registered bus (0 = NOP). Issue is
//   held while a compute instruction runs (until compute_done) and after a
//   HALT (until resume).
//
// Ports
//   clk, rst                  clock, async active-high reset
//   host_instr/valid/ready    host write side; ready = (count < DEPTH)
//   compute_done, resume      pulses releasing WAIT_COMPUTE / HALTED
//   instruction               registered issued instruction, 0 when idle
//   busy, halted              state flags (WAIT_COMPUTE, HALTED)
//   fifo_count                FIFO occupancy
//   overflow_err              sticky: host offered data while not ready
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_FETCH     | issuing from FIFO whenever it is non-empty
// ST_WAIT      | compute running, no issue until compute_done
// ST_HALT      | HALT issued, no issue until resume
module instr_fetch_queue #(
   parameter int DEPTH   = 16,
   parameter int INSTR_W = 64,
   parameter int CNT_W   = $clog2(DEPTH+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INSTR_W-1:0] host_instr,
   input  logic               host_valid,
   output logic               host_ready,
   input  logic               compute_done,
   input  logic               resume,
   output logic [INSTR_W-1:0] instruction,
   output logic               busy,
   output logic               halted,
   output logic [CNT_W-1:0]   fifo_count,
   output logic               overflow_err
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_HALT  = 2'd2;

   localparam logic [4:0] OP_COMP_A = 5'b00001;
   localparam logic [4:0] OP_COMP_B = 5'b00010;
   localparam logic [4:0] OP_HALT   = 5'b11111;

   logic [INSTR_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [1:0]         state_q, state_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               ovf_q, ovf_d;
   logic               push, pop;
   logic [INSTR_W-1:0] head;

   // Ready depends only on the current count: a full FIFO never accepts,
   // even if it is being popped in the same cycle.
   assign host_ready = (count_q < CNT_W'(DEPTH));
   assign push       = host_valid && host_ready;
   assign pop        = (state_q == ST_FETCH) && (count_q != '0);
   assign head       = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      state_d  = state_q;
      instr_d  = '0;
      ovf_d    = ovf_q | (host_valid & ~host_ready);

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      case (state_q)
         ST_FETCH: begin
            if (pop) begin
               instr_d = head;
               if (head[4:0] == OP_COMP_A || head[4:0] == OP_COMP_B)
                  state_d = ST_WAIT;
               else if (head[4:0] == OP_HALT)
                  state_d = ST_HALT;
            end
         end
         ST_WAIT: if (compute_done) state_d = ST_FETCH;
         ST_HALT: if (resume)       state_d = ST_FETCH;
         default: state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= ST_FETCH;
         instr_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         instr_q  <= instr_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset; entries are only read after being written.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= host_instr;
   end

   assign instruction  = instr_q;
   assign busy         = (state_q == ST_WAIT);
   assign halted       = (state_q == ST_HALT);
   assign fifo_count   = count_q;
   assign overflow_err = ovf_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

   localparam int DEPTH = 16;
   localparam int W     = 64;
   localparam int CW    = $clog2(DEPTH+1);

   localparam int M_FETCH = 0;
   localparam int M_WAIT  = 1;
   localparam int M_HALT  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  host_instr = '0;
   logic          host_valid = 1'b0;
   logic          host_ready;
   logic          compute_done = 1'b0;
   logic          resume = 1'b0;
   logic [W-1:0]  instruction;
   logic          busy, halted, overflow_err;
   logic [CW-1:0] fifo_count;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model
   logic [W-1:0] m_q[$];
   int           m_state = M_FETCH;
   logic [W-1:0] m_instr = '0;
   logic         m_ovf   = 1'b0;

   instr_fetch_queue #(.DEPTH(DEPTH), .INSTR_W(W)) dut (
      .clk(clk), .rst(rst),
      .host_instr(host_instr), .host_valid(host_valid), .host_ready(host_ready),
      .compute_done(compute_done), .resume(resume),
      .instruction(instruction), .busy(busy), .halted(halted),
      .fifo_count(fifo_count), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_state = M_FETCH;
      m_instr = '0;
      m_ovf   = 1'b0;
   endtask

   // One clock edge of the block, expressed with a queue and a mode number.
   task automatic model_step(input logic hv, input logic [W-1:0] d, input logic cd, input logic rs);
      bit ready, do_pop;
      logic [W-1:0] e;
      ready  = (m_q.size() < DEPTH);
      do_pop = (m_state == M_FETCH) && (m_q.size() > 0);
      if (hv && !ready) m_ovf = 1'b1;
      m_instr = '0;
      if (do_pop) begin
         e = m_q.pop_front();
         m_instr = e;
         if (e[4:0] == 5'd1 || e[4:0] == 5'd2) m_state = M_WAIT;
         else if (e[4:0] == 5'd31)             m_state = M_HALT;
      end else if (m_state == M_WAIT && cd) begin
         m_state = M_FETCH;
      end else if (m_state == M_HALT && rs) begin
         m_state = M_FETCH;
      end
      if (hv && ready) m_q.push_back(d);
   endtask

   task automatic compare_all();
      check("instruction",  instruction,  m_instr);
      check("fifo_count",   W'(fifo_count), W'(m_q.size()));
      check("busy",         W'(busy),     W'(m_state == M_WAIT));
      check("halted",       W'(halted),   W'(m_state == M_HALT));
      check("overflow_err", W'(overflow_err), W'(m_ovf));
      check("host_ready",   W'(host_ready), W'(m_q.size() < DEPTH));
   endtask

   task automatic cycle(input logic hv, input logic [W-1:0] d, input logic cd, input logic rs);
      host_valid   = hv;
      host_instr   = d;
      compute_done = cd;
      resume       = rs;
      model_step(hv, d, cd, rs);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
   endtask

   function automatic logic [W-1:0] mk(input logic [4:0] op, input logic [58:0] body);
      return {body, op};
   endfunction

   function automatic logic [W-1:0] rnd_instr();
      logic [4:0] op;
      logic [W-1:0] v;
      v = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) begin
         case ($urandom_range(0, 2))
            0:       op = 5'd1;
            1:       op = 5'd2;
            default: op = 5'd31;
         endcase
      end else begin
         op = 5'($urandom_range(0, 31));
      end
      v[4:0] = op;
      return v;
   endfunction

   initial begin
      // 1: reset then idle
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      compare_all();
      idle(10);

      // 2: latency and ordering (input-buffer load, addr 3, data DEADBEEF)
      cycle(1'b1, {24'h0, 32'hDEADBEEF, 3'd0, 5'd3, 5'b00100}, 1'b0, 1'b0);
      cycle(1'b1, {24'h0, 32'hCAFEF00D, 3'd0, 5'd4, 5'b00101}, 1'b0, 1'b0);
      idle(3);

      // 3: compute stall
      cycle(1'b1, mk(5'b00001, 59'h111), 1'b0, 1'b0);
      cycle(1'b1, mk(5'b00011, 59'h222), 1'b0, 1'b0);
      cycle(1'b1, mk(5'b00110, 59'h333), 1'b0, 1'b0);
      idle(5);
      cycle(1'b0, '0, 1'b1, 1'b0);
      idle(4);

      // 4: halt / resume, with a stray compute_done while halted
      cycle(1'b1, mk(5'b11111, 59'h444), 1'b0, 1'b0);
      cycle(1'b1, mk(5'b00111, 59'h555), 1'b0, 1'b0);
      idle(10);
      cycle(1'b0, '0, 1'b1, 1'b0);
      idle(10);
      cycle(1'b0, '0, 1'b0, 1'b1);
      idle(3);

      // 5: full and overflow while held in WAIT_COMPUTE
      cycle(1'b1, mk(5'b00010, 59'h666), 1'b0, 1'b0);
      idle(2);
      for (int i = 0; i < DEPTH; i++) cycle(1'b1, mk(5'b00011, 59'(i + 'h700)), 1'b0, 1'b0);
      cycle(1'b1, mk(5'b00011, 59'h7FF), 1'b0, 1'b0);
      idle(2);
      cycle(1'b0, '0, 1'b1, 1'b0);
      idle(DEPTH + 3);

      // 6: async reset mid-operation with 5 entries queued in WAIT_COMPUTE
      cycle(1'b1, mk(5'b00001, 59'h888), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, mk(5'b01000, 59'(i + 'h900)), 1'b0, 1'b0);
      check("pre_reset_busy", W'(busy), W'(1));
      host_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      #1 rst = 1'b0;
      cycle(1'b1, mk(5'b01001, 59'hABC), 1'b0, 1'b0);
      idle(2);

      // random phase
      for (int i = 0; i < 1500; i++) begin
         cycle(($urandom_range(0, 2) != 0), rnd_instr(),
               ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
